// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with a built-in auto-scan mode.
// Direct mode decodes `in` into a one-hot select one cycle later. Scan mode walks a
// one-hot select across all outputs. Each row is held for DWELL cycles, followed by
// BLANK all-zero cycles. frame_done pulses on the first row-0 cycle after a wrap.
// Every output comes straight from a flop, so the row/column drivers never see
// decode glitches.
module scan_decoder #(
    parameter int N     = 3,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                mode,
    input  logic [N-1:0]        in,
    output logic [(1<<N)-1:0]   out,
    output logic [N-1:0]        index,
    output logic                frame_done
);

    localparam int OUT_W   = 1 << N;
    // One counter serves both the dwell and the blank phases, so it is sized for the longer one.
    localparam int CNT_MAX = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                             : ((BLANK > 2) ? BLANK : 2);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    // With BLANK == 0 the blank phase is never entered, so this value is unused.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [N-1:0]     IDX_ONE    = N'(1);
    localparam logic [N-1:0]     LAST_ROW   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_BLANK
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       index_q, index_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               frame_done_q, frame_done_d;

    logic [N-1:0]       next_row;
    logic               wrap;

    // Returns a one-hot vector with bit `sel` set.
    function automatic logic [OUT_W-1:0] onehot(input logic [N-1:0] sel);
        onehot = OUT_W'(1) << sel;
    endfunction

    // The row index wraps naturally from 2^N-1 back to 0 in N bits.
    assign next_row = index_q + IDX_ONE;
    assign wrap     = (index_q == LAST_ROW);

    // Next-state logic. Direct mode and ena=0 override every scan transition.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        index_d      = index_q;
        out_d        = '0;
        frame_done_d = 1'b0;

        if (!mode) begin
            // Direct decode: the FSM is parked so that a later switch to scan starts at row 0.
            state_d = ST_IDLE;
            cnt_d   = '0;
            index_d = '0;
            out_d   = ena ? onehot(in) : '0;
        end else if (!ena) begin
            // Disabled while scanning: blank immediately and restart from row 0 when re-enabled.
            state_d = ST_IDLE;
            cnt_d   = '0;
            index_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Starting from idle is not a wrap, so frame_done stays low.
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    index_d = '0;
                    out_d   = onehot('0);
                end
                ST_ACTIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (BLANK > 0) begin
                            state_d = ST_BLANK;
                        end else begin
                            // No gap: step straight to the next row.
                            index_d      = next_row;
                            out_d        = onehot(next_row);
                            frame_done_d = wrap;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        out_d = onehot(index_q);
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d      = ST_ACTIVE;
                        cnt_d        = '0;
                        index_d      = next_row;
                        out_d        = onehot(next_row);
                        frame_done_d = wrap;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    index_d = '0;
                end
            endcase
        end
    end

    // State and output registers. Reset clears them immediately, even in the middle of a scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            index_q      <= '0;
            out_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            index_q      <= index_d;
            out_q        <= out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out        = out_q;
    assign index      = index_q;
    assign frame_done = frame_done_q;

`ifndef SYNTHESIS
    a_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(out_q));
    a_fd_row0: assert property (@(posedge clk) disable iff (!rst)
                                frame_done_q |-> (out_q == OUT_W'(1)));
    a_idle_ix: assert property (@(posedge clk) disable iff (!rst)
                                (state_q == ST_IDLE) |-> (index_q == '0));
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: stimulus pushes hand-computed expectations,
// and a monitor pops and compares them one cycle later.
module tb_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance a: N=2, DWELL=3, BLANK=1
    logic       ena_a = 1'b0, mode_a = 1'b0;
    logic [1:0] in_a  = '0;
    logic [3:0] out_a;
    logic [1:0] idx_a;
    logic       fd_a;
    // Instance b: N=2, DWELL=2, BLANK=0
    logic       ena_b = 1'b0, mode_b = 1'b0;
    logic [1:0] in_b  = '0;
    logic [3:0] out_b;
    logic [1:0] idx_b;
    logic       fd_b;
    // Instance c: N=3, DWELL=4, BLANK=1
    logic       ena_c = 1'b0, mode_c = 1'b0;
    logic [2:0] in_c  = '0;
    logic [7:0] out_c;
    logic [2:0] idx_c;
    logic       fd_c;

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       fd;
        string      tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    int checks   = 0;
    int failures = 0;

    // Expected outputs for N=2, DWELL=3, BLANK=1, cycles 1..21 after scan start.
    logic [3:0] T2_OUT [0:20] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                  4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000,
                                  4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    int         T2_IDX [0:20] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1};
    // Expected outputs for N=2, DWELL=2, BLANK=0, cycles 1..11 after scan start.
    logic [3:0] T3_OUT [0:10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                  4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
    int         T3_IDX [0:10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1};

    scan_decoder #(.N(2), .DWELL(3), .BLANK(1)) u_a (
        .clk(clk), .rst(rst), .ena(ena_a), .mode(mode_a), .in(in_a),
        .out(out_a), .index(idx_a), .frame_done(fd_a)
    );
    scan_decoder #(.N(2), .DWELL(2), .BLANK(0)) u_b (
        .clk(clk), .rst(rst), .ena(ena_b), .mode(mode_b), .in(in_b),
        .out(out_b), .index(idx_b), .frame_done(fd_b)
    );
    scan_decoder #(.N(3), .DWELL(4), .BLANK(1)) u_c (
        .clk(clk), .rst(rst), .ena(ena_c), .mode(mode_c), .in(in_c),
        .out(out_c), .index(idx_c), .frame_done(fd_c)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag,
                           input logic [7:0] ao, input logic [2:0] ai, input logic af,
                           input logic [7:0] eo, input logic [2:0] ei, input logic ef);
        checks++;
        if (ao !== eo || ai !== ei || af !== ef) begin
            failures++;
            $display("FAIL %s @%0t: got out=%b index=%0d frame_done=%b, expected out=%b index=%0d frame_done=%b",
                     tag, $time, ao, ai, af, eo, ei, ef);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input int dut, input logic e, input logic m, input logic [2:0] i,
                        input logic [7:0] eo, input logic [2:0] ei, input logic ef,
                        input string tag);
        exp_t x;
        @(negedge clk);
        x.out = eo;
        x.idx = ei;
        x.fd  = ef;
        x.tag = tag;
        case (dut)
            0: begin ena_a = e; mode_a = m; in_a = i[1:0]; q_a.push_back(x); end
            1: begin ena_b = e; mode_b = m; in_b = i[1:0]; q_b.push_back(x); end
            default: begin ena_c = e; mode_c = m; in_c = i; q_c.push_back(x); end
        endcase
    endtask

    // Monitor: compare each queued expectation against the registered outputs.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            e_a = q_a.pop_front();
            compare(e_a.tag, {4'b0, out_a}, {1'b0, idx_a}, fd_a, e_a.out, e_a.idx, e_a.fd);
        end
        if (q_b.size() > 0) begin
            e_b = q_b.pop_front();
            compare(e_b.tag, {4'b0, out_b}, {1'b0, idx_b}, fd_b, e_b.out, e_b.idx, e_b.fd);
        end
        if (q_c.size() > 0) begin
            e_c = q_c.pop_front();
            compare(e_c.tag, out_c, idx_c, fd_c, e_c.out, e_c.idx, e_c.fd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, checked before any clock edge.
        #1 rst = 1'b0;
        #1;
        compare("reset_a", {4'b0, out_a}, {1'b0, idx_a}, fd_a, 8'd0, 3'd0, 1'b0);
        compare("reset_b", {4'b0, out_b}, {1'b0, idx_b}, fd_b, 8'd0, 3'd0, 1'b0);
        compare("reset_c", out_c, idx_c, fd_c, 8'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Direct decode.
        step(0, 1'b1, 1'b0, 3'd2, 8'b0100, 3'd0, 1'b0, "direct_in2");
        step(0, 1'b1, 1'b0, 3'd3, 8'b1000, 3'd0, 1'b0, "direct_in3");
        step(0, 1'b0, 1'b0, 3'd3, 8'b0000, 3'd0, 1'b0, "direct_ena0");
        step(0, 1'b1, 1'b0, 3'd0, 8'b0001, 3'd0, 1'b0, "direct_in0");
        step(0, 1'b1, 1'b0, 3'd1, 8'b0010, 3'd0, 1'b0, "direct_in1");
        step(0, 1'b0, 1'b0, 3'd0, 8'b0000, 3'd0, 1'b0, "direct_off");

        // Full scan with a blank gap and one wrap.
        for (int k = 1; k <= 21; k++)
            step(0, 1'b1, 1'b1, 3'd0, {4'b0, T2_OUT[k-1]}, 3'(T2_IDX[k-1]), (k == 17), "scan_blank1");
        step(0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, "scan_stop");

        // Abort mid-scan, then restart from row 0.
        for (int k = 1; k <= 6; k++)
            step(0, 1'b1, 1'b1, 3'd0, {4'b0, T2_OUT[k-1]}, 3'(T2_IDX[k-1]), 1'b0, "abort_pre");
        for (int k = 7; k <= 9; k++)
            step(0, 1'b0, 1'b1, 3'd0, 8'd0, 3'd0, 1'b0, "abort_ena0");
        for (int k = 10; k <= 14; k++)
            step(0, 1'b1, 1'b1, 3'd0, {4'b0, T2_OUT[k-10]}, 3'(T2_IDX[k-10]), 1'b0, "abort_restart");
        step(0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, "abort_stop");

        // ena drop on the blank cycle that would wrap: no frame_done, restart at row 0.
        for (int k = 1; k <= 16; k++)
            step(0, 1'b1, 1'b1, 3'd0, {4'b0, T2_OUT[k-1]}, 3'(T2_IDX[k-1]), 1'b0, "enawins_pre");
        step(0, 1'b0, 1'b1, 3'd0, 8'd0, 3'd0, 1'b0, "enawins_wrap");
        step(0, 1'b1, 1'b1, 3'd0, 8'b0001, 3'd0, 1'b0, "enawins_restart");
        step(0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, "enawins_stop");

        // Asynchronous reset during row 2.
        for (int k = 1; k <= 10; k++)
            step(0, 1'b1, 1'b1, 3'd0, {4'b0, T2_OUT[k-1]}, 3'(T2_IDX[k-1]), 1'b0, "areset_pre");
        @(posedge clk);
        #3;
        rst    = 1'b0;
        ena_a  = 1'b0;
        mode_a = 1'b0;
        #1;
        compare("areset_immediate", {4'b0, out_a}, {1'b0, idx_a}, fd_a, 8'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 5; k++)
            step(0, 1'b1, 1'b1, 3'd0, {4'b0, T2_OUT[k-1]}, 3'(T2_IDX[k-1]), 1'b0, "areset_rescan");
        step(0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, "areset_stop");

        // Scan without a blank gap.
        for (int k = 1; k <= 11; k++)
            step(1, 1'b1, 1'b1, 3'd0, {4'b0, T3_OUT[k-1]}, 3'(T3_IDX[k-1]), (k == 9), "scan_blank0");
        step(1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, "blank0_stop");

        // N=3: scan to row 5, switch to direct, then back to scan.
        for (int k = 1; k <= 27; k++) begin
            int row, ph;
            row = (k - 1) / 5;
            ph  = (k - 1) % 5;
            step(2, 1'b1, 1'b1, 3'd0, (ph < 4) ? (8'd1 << row) : 8'd0, 3'(row), 1'b0, "n3_scan");
        end
        step(2, 1'b1, 1'b0, 3'd1, 8'b00000010, 3'd0, 1'b0, "n3_to_direct");
        step(2, 1'b1, 1'b1, 3'd1, 8'b00000001, 3'd0, 1'b0, "n3_to_scan");
        step(2, 1'b1, 1'b1, 3'd1, 8'b00000001, 3'd0, 1'b0, "n3_scan_hold");
        step(2, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, "n3_stop");

        repeat (3) @(negedge clk);
        checks++;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0",
                     q_a.size() + q_b.size() + q_c.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
